div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle divider in the EX stage. It is the consumer end of the alucontrol bus produced by the ALU decoder.
- Accepts DIV/DIVU when alucontrol equals `EXE_DIV_OP` / `EXE_DIVU_OP` (defines.vh), iterates radix-2 restoring division, and returns quotient (LO) and remainder (HI) for the HI/LO writeback path.
- Holds the pipeline via busy while iterating.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are WIDTH bits each.
- ITERS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- alucontrol  input  8  EX-stage ALU control code.
- valid_i  input  1  EX-stage instruction valid (not bubble/stalled-out).
- annul  input  1  flush (exception/eret); cancels any operation.
- a  input  WIDTH  dividend (rs value).
- b  input  WIDTH  divisor (rt value).
- busy  output  1  high while an operation is in flight; drives EX stall.
- done  output  1  one-cycle pulse when hi_o/lo_o are updated.
- hi_o  output  WIDTH  remainder.
- lo_o  output  WIDTH  quotient.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on resetn.
- Reset values: state=IDLE, busy=0, done=0, hi_o=0, lo_o=0, internal registers 0.
- States: IDLE, RUN, DONE.
- Accept condition: state==IDLE && valid_i && !annul && alucontrol in {`EXE_DIV_OP`, `EXE_DIVU_OP`}. Call the accept cycle T.
- On accept:
  - latch signed flag (DIV=1, DIVU=0);
  - latch |a| and |b| (two's-complement negate if signed and MSB set, else raw);
  - latch sign_q = a[31]^b[31] and sign_r = a[31], both only when signed;
  - clear the iteration counter.
- Divide by zero: if b==0 at accept, go directly to DONE.
  - At T+1: done=1, lo_o=all ones, hi_o=a.
- Otherwise go to RUN.
  - Each RUN cycle: shift the {rem,quo} pair left by 1; if rem>=|b|, subtract and set the quotient LSB.
  - Counter increments 0..ITERS-1; after ITERS RUN cycles go to DONE.
- DONE state:
  - occurs at T+ITERS+1 (T+33 by default);
  - done=1 for exactly one cycle;
  - lo_o = sign_q ? -quo : quo;
  - hi_o = sign_r ? -rem : rem;
  - next state IDLE.
- hi_o/lo_o hold their value until the next done. Widths truncate to WIDTH; no overflow flag.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo_o=0x80000000, hi_o=0.
- busy = (state!=IDLE), registered from the state. It is 0 in the accept cycle T, so the stage stall logic must OR in the accept condition; busy is 1 from T+1 through the DONE cycle.
- valid_i/alucontrol while state!=IDLE: ignored. Operands are not re-sampled.
- Non-div alucontrol codes: no effect.
- annul in any state: next state IDLE, no done pulse, hi_o/lo_o unchanged.
- annul in the same cycle as an accept condition: annul wins, nothing starts.
- An accept in the cycle after DONE (state IDLE) is legal; back-to-back operations have no dead cycle beyond DONE.
- Reset asserted mid-operation: immediate return to reset values, no done.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - at accept, if b!=0 and |a|<|b| (unsigned compare of latched magnitudes), skip RUN and go directly to DONE;
  - at T+1: done=1, lo_o=0, hi_o=a (original signed dividend);
  - b==0 takes priority over early-out.
- Undefined: every non-zero-divisor operation takes the full ITERS RUN cycles, with done at T+33.

Test Plan:
- DIVU a=100, b=7 -> done at T+33, lo_o=14, hi_o=2; busy high T+1..T+33.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU a=5, b=0 -> done at T+1, lo_o=0xFFFFFFFF, hi_o=5.
- Start DIVU 100/7, assert annul at T+10 -> state IDLE at T+11, no done, hi_o/lo_o keep previous values. annul together with valid DIV -> busy stays 0.
- Back-to-back: DIVU 9/3 then DIV 9/-3 accepted the cycle after the first done -> done pulses 34 cycles apart with (lo=3, hi=0) then (lo=0xFFFFFFFD, hi=0). A second valid DIV while busy is ignored.
- DIV_EARLY_OUT_EN defined: DIVU 3/10 -> done at T+1, lo_o=0, hi_o=3. Undefined: same stimulus -> done at T+33, same values.

Source files
------------

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle radix-2 restoring divider for the EX stage.
//
// Accepts DIV (signed) and DIVU (unsigned) from the ALU decoder's alucontrol
// bus. It returns the quotient on lo_o and the remainder on hi_o for the HI/LO
// writeback path, and raises busy while an operation is in flight.
//
// Ports:
//   clk        in   rising-edge system clock
//   resetn     in   asynchronous active-low reset
//   alucontrol in   [7:0]  EX-stage ALU control code
//   valid_i    in   EX-stage instruction valid
//   annul      in   flush; cancels any operation, no done pulse
//   a          in   [WIDTH-1:0] dividend (rs)
//   b          in   [WIDTH-1:0] divisor (rt)
//   busy       out  state != IDLE (registered); drives EX stall
//   done       out  one-cycle pulse in the cycle hi_o/lo_o take a new result
//   hi_o       out  [WIDTH-1:0] remainder
//   lo_o       out  [WIDTH-1:0] quotient
//   dbg_state  out  [1:0] current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Op codes come from defines.vh (EXE_DIV_OP / EXE_DIVU_OP). The fallback
// values below are used when that header has not been included.
//
// Optional build macro: DIV_EARLY_OUT_EN. When it is defined, a non-zero
// divisor with |a| < |b| finishes in one cycle (quotient 0, remainder a).
// -----------------------------------------------------------------------------
`ifndef EXE_DIV_OP
`define EXE_DIV_OP 8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32   // must equal WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic             valid_i,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_sign_q;   // negate quotient at the end (signed only)
  logic             r_sign_r;   // negate remainder at the end (signed only)
  logic [WIDTH-1:0] r_div;      // |b|
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_quo;      // dividend bits shifting out, quotient bits in
  logic [CW-1:0]    r_cnt;

  // Handshake: there is no ready output. An instruction is taken when
  // valid_i is high, the unit is IDLE, annul is low and the op code is
  // DIV/DIVU. busy is registered, so it is still 0 in the accept cycle; the
  // stall logic must OR in the accept condition. While busy, valid_i and the
  // operands are ignored and never re-sampled.
  logic w_is_div;
  logic w_is_divu;
  logic w_accept;
  assign w_is_div  = (alucontrol == `EXE_DIV_OP);
  assign w_is_divu = (alucontrol == `EXE_DIVU_OP);
  assign w_accept  = (r_state == S_IDLE) && valid_i && !annul && (w_is_div || w_is_divu);

  // Operand magnitudes. These are negated only for a signed op with the MSB set.
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_b_zero;
  logic             w_early;
  assign w_a_neg  = w_is_div && a[WIDTH-1];
  assign w_b_neg  = w_is_div && b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? (~a + 1'b1) : a;
  assign w_abs_b  = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_b_zero && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step. The shifted remainder needs WIDTH+1 bits, because
  // the remainder can be as large as |b|-1 before the shift.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_lo_fin;
  logic [WIDTH-1:0] w_hi_fin;
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[WIDTH-1:0] - r_div;   // exact whenever w_ge
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == CW'(ITERS - 1));
  assign w_lo_fin  = r_sign_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_hi_fin  = r_sign_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state. annul overrides everything and returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (annul) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_state_nxt = (w_b_zero || w_early) ? S_DONE : S_RUN;
        S_RUN:  if (w_last)   w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  // Datapath. The results are written on the edge that enters DONE, so they
  // are already valid in the done cycle and then hold until the next result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else if (w_accept) begin
      r_sign_q <= w_is_div && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_sign_r <= w_is_div && a[WIDTH-1];
      r_div    <= w_abs_b;
      r_rem    <= '0;
      r_quo    <= w_abs_a;
      r_cnt    <= '0;
      if (w_b_zero) begin
        lo_o <= '1;
        hi_o <= a;
      end else if (w_early) begin
        lo_o <= '0;
        hi_o <= a;
      end
    end else if (r_state == S_RUN && !annul) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        lo_o <= w_lo_fin;
        hi_o <= w_hi_fin;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
`ifndef EXE_DIV_OP
`define EXE_DIV_OP 8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module tb_div_unit;

  localparam logic [7:0] OP_DIV  = `EXE_DIV_OP;
  localparam logic [7:0] OP_DIVU = `EXE_DIVU_OP;
  localparam logic [7:0] OP_ADD  = 8'b00100000;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        valid_i;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [63:0] exp_q[$];          // expected {hi, lo}
  logic [31:0] last_hi, last_lo;  // last result the bench expects to be held

  div_unit dut (
    .clk(clk), .resetn(resetn), .alucontrol(alucontrol), .valid_i(valid_i),
    .annul(annul), .a(a), .b(b), .busy(busy), .done(done),
    .hi_o(hi_o), .lo_o(lo_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  // Uses the language's own division. Signed division truncates toward zero,
  // and the remainder takes the sign of the dividend.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] aa, input logic [31:0] bb);
    longint sa, sb, q, r;
    if (bb == 32'd0) return {aa, 32'hFFFF_FFFF};
    if (!sgn) return {aa % bb, aa / bb};
    sa = $signed(aa);
    sb = $signed(bb);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input bit sgn, input logic [31:0] aa, input logic [31:0] bb);
    logic [31:0] ma, mb;
    ma = (sgn && aa[31]) ? -aa : aa;
    mb = (sgn && bb[31]) ? -bb : bb;
    if (bb == 32'd0) return 1;
    if (EARLY_EN && (ma < mb)) return 1;
    return 33;
  endfunction

  // ---------------- driver ----------------
  // Present one op for a single cycle (T), then wait for done.
  // lat = cycles from T to the done cycle.
  task automatic run_op(input logic [7:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output int done_cyc, output bit busy_t, output bit busy_ok);
    @(negedge clk);
    alucontrol = op; valid_i = 1'b1; a = aa; b = bb; annul = 1'b0;
    #1 busy_t = busy;
    @(negedge clk);
    valid_i = 1'b0; alucontrol = OP_ADD; a = $urandom; b = $urandom;
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    hi = hi_o; lo = lo_o; done_cyc = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; valid_i = 1'b0; annul = 1'b0; alucontrol = 8'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if ({hi_o, lo_o} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {hi_o, lo_o}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    resetn = 1'b1;
    last_hi = '0; last_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat, dc; logic [31:0] hi, lo; bit bt, bok; logic [63:0] e;
    exp_q.push_back({32'd2, 32'd14});
    run_op(OP_DIVU, 32'd100, 32'd7, lat, hi, lo, dc, bt, bok);
    e = exp_q.pop_front();
    checks++; if (bt !== 1'b0) begin failures++; $display("FAIL divu_busy_T got=%0b exp=0", bt); end
    checks++; if (lat != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (!bok) begin failures++; $display("FAIL divu_busy_run got=0 exp=1"); end
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", {hi, lo}, e); end
    last_hi = e[63:32]; last_lo = e[31:0];
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL divu_after_done got=%b exp=00", {busy, done}); end
  endtask

  // Directed signed/overflow/zero-divisor cases
  task automatic test_div_cases();
    logic [7:0]  ops [5] = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7, 32'd3};
    logic [31:0] bs  [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd10};
    logic [63:0] fix [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                             {32'd5, 32'hFFFF_FFFF}, {32'hFFFF_FFF7, 32'hFFFF_FFFF},
                             {32'd3, 32'd0}};
    int lat, dc; logic [31:0] hi, lo; bit bt, bok; logic [63:0] e; int el;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(fix[i]);
      run_op(ops[i], as[i], bs[i], lat, hi, lo, dc, bt, bok);
      e = exp_q.pop_front();
      el = (bs[i] == 0) ? 1 : ((EARLY_EN && i == 4) ? 1 : 33);
      checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL case%0d_value got=%h exp=%h", i, {hi, lo}, e); end
      checks++; if (lat != el) begin failures++; $display("FAIL case%0d_latency got=%0d exp=%0d", i, lat, el); end
      checks++; if (!bok) begin failures++; $display("FAIL case%0d_busy got=0 exp=1", i); end
      last_hi = e[63:32]; last_lo = e[31:0];
    end
  endtask

  task automatic test_annul();
    bit saw_done = 1'b0;
    @(negedge clk);
    alucontrol = OP_DIVU; valid_i = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);                       // T+1
    valid_i = 1'b0; alucontrol = OP_ADD;
    repeat (9) begin @(negedge clk); if (done) saw_done = 1'b1; end   // T+10
    annul = 1'b1;
    @(negedge clk);                       // T+11
    annul = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL annul_idle got=%0b exp=0", busy); end
    repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL annul_no_done got=1 exp=0"); end
    checks++; if ({hi_o, lo_o} !== {last_hi, last_lo}) begin
      failures++; $display("FAIL annul_hold got=%h exp=%h", {hi_o, lo_o}, {last_hi, last_lo}); end
    // annul in the same cycle as a valid DIV
    @(negedge clk);
    alucontrol = OP_DIV; valid_i = 1'b1; annul = 1'b1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    valid_i = 1'b0; annul = 1'b0; alucontrol = OP_ADD;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL annul_accept_busy got=%0b exp=0", busy); end
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL annul_accept_start got=1 exp=0"); end
  endtask

  task automatic test_non_div();
    bit act = 1'b0;
    @(negedge clk);
    alucontrol = OP_ADD; valid_i = 1'b1; a = 32'd100; b = 32'd7;
    repeat (3) begin @(negedge clk); if (busy || done) act = 1'b1; end
    valid_i = 1'b0;
    repeat (40) begin @(negedge clk); if (busy || done) act = 1'b1; end
    checks++; if (act) begin failures++; $display("FAIL non_div_ignored got=1 exp=0"); end
    checks++; if ({hi_o, lo_o} !== {last_hi, last_lo}) begin
      failures++; $display("FAIL non_div_hold got=%h exp=%h", {hi_o, lo_o}, {last_hi, last_lo}); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, dc1, dc2; logic [31:0] hi1, lo1, hi2, lo2; bit bt, bok1, bok2; logic [63:0] e;
    exp_q.push_back(model(1'b0, 32'd9, 32'd3));
    exp_q.push_back(model(1'b1, 32'd9, 32'hFFFF_FFFD));
    run_op(OP_DIVU, 32'd9, 32'd3, lat1, hi1, lo1, dc1, bt, bok1);
    run_op(OP_DIV, 32'd9, 32'hFFFF_FFFD, lat2, hi2, lo2, dc2, bt, bok2);
    checks++; if (bt !== 1'b0) begin failures++; $display("FAIL b2b_accept_idle got=%0b exp=0", bt); end
    checks++; if (dc2 - dc1 != 34) begin failures++; $display("FAIL b2b_spacing got=%0d exp=34", dc2 - dc1); end
    e = exp_q.pop_front();
    checks++; if ({hi1, lo1} !== e || e !== {32'd0, 32'd3}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi1, lo1}, e); end
    e = exp_q.pop_front();
    checks++; if ({hi2, lo2} !== e || e !== {32'd0, 32'hFFFF_FFFD}) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi2, lo2}, e); end
    last_hi = e[63:32]; last_lo = e[31:0];
  endtask

  task automatic test_ignore_busy();
    int lat = 1;
    @(negedge clk);
    alucontrol = OP_DIVU; valid_i = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);                               // T+1: offer a new DIV while busy
    alucontrol = OP_DIV; a = $urandom; b = 32'd1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 6) valid_i = 1'b0;
      @(negedge clk); lat++;
      a = $urandom;
    end
    valid_i = 1'b0; alucontrol = OP_ADD;
    checks++; if (lat != 33) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=33", lat); end
    checks++; if ({hi_o, lo_o} !== model(1'b0, 32'd100, 32'd7)) begin
      failures++; $display("FAIL busy_ignore_value got=%h exp=%h", {hi_o, lo_o}, model(1'b0, 32'd100, 32'd7)); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_ignore_restart got=%0b exp=0", busy); end
    last_hi = 32'd2; last_lo = 32'd14;
  endtask

  task automatic test_random();
    int lat, dc, el; logic [31:0] hi, lo, ra, rb; bit bt, bok, sgn; logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      sgn = $urandom_range(0, 1);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1, 2: rb = $urandom_range(1, 20);
        3: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = $urandom_range(0, 30);
      e  = model(sgn, ra, rb);
      el = exp_lat(sgn, ra, rb);
      exp_q.push_back(e);
      run_op(sgn ? OP_DIV : OP_DIVU, ra, rb, lat, hi, lo, dc, bt, bok);
      e = exp_q.pop_front();
      checks++; if ({hi, lo} !== e) begin failures++;
        $display("FAIL rand%0d_value sgn=%0b a=%h b=%h got=%h exp=%h", i, sgn, ra, rb, {hi, lo}, e); end
      checks++; if (lat != el) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, el); end
      last_hi = e[63:32]; last_lo = e[31:0];
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alucontrol = OP_DIVU; valid_i = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    valid_i = 1'b0; alucontrol = OP_ADD;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL midreset_ctrl got=%b exp=00", {busy, done}); end
    checks++; if ({hi_o, lo_o} !== 64'd0) begin failures++; $display("FAIL midreset_hilo got=%h exp=0", {hi_o, lo_o}); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%0b exp=0", busy); end
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_divu_basic();
    test_div_cases();
    test_annul();
    test_non_div();
    test_back_to_back();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
